// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RISC-V core: decodes the IR and sequences
// the shared datapath through fetch/decode/execute/memory/writeback.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] Opcode,
    input  logic [2:0] Funct3,
    input  logic       Funct7b5,
    input  logic       Zero,
    input  logic       SignBit,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [2:0] ALUOp,
    output logic       LtFlag,
    output logic       Illegal
);

    localparam int unsigned OP_W  = 7;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned IMM_W = 3;
    localparam int unsigned ALU_W = 3;

    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;

    localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALU_W-1:0] ALU_XOR = 3'b100;

    localparam logic [IMM_W-1:0] IMM_I = 3'b000;
    localparam logic [IMM_W-1:0] IMM_S = 3'b001;
    localparam logic [IMM_W-1:0] IMM_B = 3'b010;
    localparam logic [IMM_W-1:0] IMM_U = 3'b100;

    localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
    localparam logic [SEL_W-1:0] RES_MEM    = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALU    = 2'b10;
    localparam logic [SEL_W-1:0] RES_LT     = 2'b11;

    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;
    localparam logic [SEL_W-1:0] SRCA_ZERO  = 2'b11;

    localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_LUI, S_ILLEGAL
    } state_t;

    state_t state, state_next;

    logic       alu_f3_ok_c;
    logic       is_slt_c;
    logic       is_store_c;
    state_t     decode_target_c;
    logic [2:0] exec_aluop_c;
    logic       pcwrite_c, memwrite_c, irwrite_c, regwrite_c;

    // Funct3 codes the ALU instruction groups implement (no shifts, no sltu)
    always_comb begin
        alu_f3_ok_c = 1'b0;
        case (Funct3)
            F3_ADD, F3_SLT, F3_XOR, F3_OR, F3_AND: alu_f3_ok_c = 1'b1;
            default:                               alu_f3_ok_c = 1'b0;
        endcase
    end

    assign is_slt_c   = ((Opcode == OP_RTYPE) || (Opcode == OP_ITYPE)) && (Funct3 == F3_SLT);
    assign is_store_c = Opcode[5];

    // DECODE dispatch; unsupported opcode/funct combinations divert to ILLEGAL
    always_comb begin
        decode_target_c = S_ILLEGAL;
        case (Opcode)
            OP_LOAD, OP_STORE:
                if (Funct3 == F3_WORD) decode_target_c = S_MEMADR;
            OP_RTYPE:
                if (alu_f3_ok_c && (!Funct7b5 || (Funct3 == F3_ADD))) decode_target_c = S_EXECR;
            OP_ITYPE:
                if (alu_f3_ok_c) decode_target_c = S_EXECI;
            OP_BRANCH:
                if ((Funct3 == F3_BEQ) || (Funct3 == F3_BNE) ||
                    (Funct3 == F3_BLT) || (Funct3 == F3_BGE)) decode_target_c = S_BRANCH;
            OP_JAL:  decode_target_c = S_JAL;
            OP_LUI:  decode_target_c = S_LUI;
            default: decode_target_c = S_ILLEGAL;
        endcase
    end

    // ALU operation for EXECR/EXECI; IR[30] selects sub only for R-type
    always_comb begin
        exec_aluop_c = ALU_ADD;
        case (Funct3)
            F3_ADD:  exec_aluop_c = ((Opcode == OP_RTYPE) && Funct7b5) ? ALU_SUB : ALU_ADD;
            F3_SLT:  exec_aluop_c = ALU_SUB;
            F3_XOR:  exec_aluop_c = ALU_XOR;
            F3_OR:   exec_aluop_c = ALU_OR;
            F3_AND:  exec_aluop_c = ALU_AND;
            default: exec_aluop_c = ALU_ADD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= state_next;
    end

    // LtFlag captures the ALU sign at the end of execute; Illegal is sticky
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            LtFlag  <= 1'b0;
            Illegal <= 1'b0;
        end else begin
            if ((state == S_EXECR) || (state == S_EXECI)) LtFlag <= SignBit;
            if ((state == S_DECODE) && (decode_target_c == S_ILLEGAL)) Illegal <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        pcwrite_c  = 1'b0;
        AdrSrc     = 1'b0;
        memwrite_c = 1'b0;
        irwrite_c  = 1'b0;
        regwrite_c = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RS2;
        ImmSrc     = IMM_I;
        ALUOp      = ALU_ADD;
        case (state)
            S_FETCH: begin
                irwrite_c  = 1'b1;
                pcwrite_c  = 1'b1;
                ALUSrcA    = SRCA_PC;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALU;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_B;
                state_next = decode_target_c;
            end
            S_MEMADR: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = is_store_c ? IMM_S : IMM_I;
                state_next = is_store_c ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc     = 1'b1;
                state_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = RES_MEM;
                regwrite_c = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                memwrite_c = 1'b1;
                state_next = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_RS2;
                ALUOp      = exec_aluop_c;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_I;
                ALUOp      = exec_aluop_c;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite_c = 1'b1;
                ResultSrc  = is_slt_c ? RES_LT : RES_ALUOUT;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_RS2;
                ALUOp      = ALU_SUB;
                ResultSrc  = RES_ALUOUT;
                case (Funct3)
                    F3_BEQ:  pcwrite_c = Zero;
                    F3_BNE:  pcwrite_c = ~Zero;
                    F3_BLT:  pcwrite_c = SignBit;
                    F3_BGE:  pcwrite_c = ~SignBit;
                    default: pcwrite_c = 1'b0;
                endcase
                state_next = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALUOUT;
                pcwrite_c  = 1'b1;
                state_next = S_ALUWB;
            end
            S_LUI: begin
                ALUSrcA    = SRCA_ZERO;
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_U;
                state_next = S_ALUWB;
            end
            S_ILLEGAL: state_next = S_ILLEGAL;
            default:   state_next = S_FETCH;
        endcase
    end

    // Write enables are held off for the whole time rst is high
    assign PCWrite  = pcwrite_c  & ~rst;
    assign MemWrite = memwrite_c & ~rst;
    assign IRWrite  = irwrite_c  & ~rst;
    assign RegWrite = regwrite_c & ~rst;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class cycle by
// cycle and compares all outputs against hand-written expected vectors.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] Opcode;
    logic [2:0] Funct3;
    logic       Funct7b5, Zero, SignBit;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, LtFlag, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc, ALUOp;

    int checks   = 0;
    int failures = 0;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .Opcode(Opcode), .Funct3(Funct3), .Funct7b5(Funct7b5),
        .Zero(Zero), .SignBit(SignBit), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUOp(ALUOp), .LtFlag(LtFlag), .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    logic [18:0] obs;
    assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
                  ALUSrcB, ImmSrc, ALUOp, LtFlag, Illegal};

    // Field order: pcw adr mw irw rw | rs sa sb | imm aluop | lt ill
    function automatic logic [18:0] ov(input logic pcw, adr, mw, irw, rw,
                                       input logic [1:0] rs, sa, sb,
                                       input logic [2:0] imm, op,
                                       input logic lt, ill);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, op, lt, ill};
    endfunction

    function automatic logic [18:0] fetch_v(input logic lt);
        return ov(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, lt, 0);
    endfunction

    function automatic logic [18:0] decode_v(input logic lt);
        return ov(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b010, 3'b000, lt, 0);
    endfunction

    function automatic logic [18:0] aluwb_v(input logic [1:0] rs, input logic lt);
        return ov(0, 0, 0, 0, 1, rs, 2'b00, 2'b00, 3'b000, 3'b000, lt, 0);
    endfunction

    localparam logic [18:0] RESET_V = 19'b0_0_0_0_0_10_00_10_000_000_0_0;
    localparam logic [18:0] ILL_V   = 19'b0_0_0_0_0_00_00_00_000_000_0_1;

    task automatic check(input string tag, input logic [18:0] got, input logic [18:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Check the current cycle's outputs, then advance to the next cycle
    task automatic cyc(input string tag, input logic [18:0] exp);
        #1;
        check(tag, obs, exp);
        @(negedge clk);
    endtask

    task automatic setir(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        Opcode = op; Funct3 = f3; Funct7b5 = f7;
    endtask

    initial begin
        rst = 1'b1; Zero = 1'b0; SignBit = 1'b0;
        setir(7'b0110011, 3'b000, 1'b0);
        @(negedge clk);
        cyc("reset", RESET_V);
        rst = 1'b0;

        // add
        cyc("add_fetch", fetch_v(0));
        cyc("add_decode", decode_v(0));
        cyc("add_execr", ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b000, 0, 0));
        cyc("add_aluwb", aluwb_v(2'b00, 0));

        // sub
        setir(7'b0110011, 3'b000, 1'b1);
        cyc("sub_fetch", fetch_v(0));
        cyc("sub_decode", decode_v(0));
        cyc("sub_execr", ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b001, 0, 0));
        cyc("sub_aluwb", aluwb_v(2'b00, 0));

        // xori
        setir(7'b0010011, 3'b100, 1'b0);
        cyc("xori_fetch", fetch_v(0));
        cyc("xori_decode", decode_v(0));
        cyc("xori_execi", ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b100, 0, 0));
        cyc("xori_aluwb", aluwb_v(2'b00, 0));

        // lw: 5 cycles
        setir(7'b0000011, 3'b010, 1'b0);
        cyc("lw_fetch", fetch_v(0));
        cyc("lw_decode", decode_v(0));
        cyc("lw_memadr", ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0, 0));
        cyc("lw_memread", ov(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0));
        cyc("lw_memwb", ov(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0));

        // sw: 4 cycles
        setir(7'b0100011, 3'b010, 1'b0);
        cyc("sw_fetch", fetch_v(0));
        cyc("sw_decode", decode_v(0));
        cyc("sw_memadr", ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, 3'b000, 0, 0));
        cyc("sw_memwrite", ov(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0));

        // beq taken, bne not taken, blt taken: 3 cycles each
        setir(7'b1100011, 3'b000, 1'b0); Zero = 1'b1;
        cyc("beq_fetch", fetch_v(0));
        cyc("beq_decode", decode_v(0));
        cyc("beq_branch", ov(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b001, 0, 0));
        setir(7'b1100011, 3'b001, 1'b0);
        cyc("bne_fetch", fetch_v(0));
        cyc("bne_decode", decode_v(0));
        cyc("bne_branch", ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b001, 0, 0));
        setir(7'b1100011, 3'b100, 1'b0); Zero = 1'b0; SignBit = 1'b1;
        cyc("blt_fetch", fetch_v(0));
        cyc("blt_decode", decode_v(0));
        cyc("blt_branch", ov(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b001, 0, 0));

        // slt with negative difference sets LtFlag
        setir(7'b0110011, 3'b010, 1'b0);
        cyc("slt1_fetch", fetch_v(0));
        cyc("slt1_decode", decode_v(0));
        cyc("slt1_execr", ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b001, 0, 0));
        cyc("slt1_aluwb", aluwb_v(2'b11, 1));
        // slt with non-negative difference clears it
        SignBit = 1'b0;
        cyc("slt0_fetch", fetch_v(1));
        cyc("slt0_decode", decode_v(1));
        cyc("slt0_execr", ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b001, 1, 0));
        cyc("slt0_aluwb", aluwb_v(2'b11, 0));

        // lui
        setir(7'b0110111, 3'b000, 1'b0);
        cyc("lui_fetch", fetch_v(0));
        cyc("lui_decode", decode_v(0));
        cyc("lui_lui", ov(0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 3'b100, 3'b000, 0, 0));
        cyc("lui_aluwb", aluwb_v(2'b00, 0));

        // unsupported opcode: ILLEGAL holds with all enables low
        setir(7'b1111111, 3'b000, 1'b0);
        cyc("ill_fetch", fetch_v(0));
        cyc("ill_decode", decode_v(0));
        for (int i = 0; i < 10; i++) cyc($sformatf("ill_hold%0d", i), ILL_V);

        // reset clears Illegal
        rst = 1'b1;
        cyc("ill_reset", RESET_V);
        rst = 1'b0;

        // jal, aborted by reset while in JAL
        setir(7'b1101111, 3'b000, 1'b0);
        cyc("jal_fetch", fetch_v(0));
        cyc("jal_decode", decode_v(0));
        #1 check("jal_jal", obs, ov(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000, 0, 0));
        #1 rst = 1'b1;
        #1 check("jal_rst_async", obs, RESET_V);
        @(negedge clk);
        cyc("jal_rst_hold", RESET_V);
        rst = 1'b0;
        cyc("post_rst_fetch", fetch_v(0));

        // R-type with Funct7b5=1 on xor is illegal
        setir(7'b0110011, 3'b100, 1'b1);
        cyc("badr_decode", decode_v(0));
        cyc("badr_illegal", ILL_V);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
